wb2apb_bridge: RTL and testbench
================================

WB2APB_BRIDGE -- requirements
Module: wb2apb_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, 32, address width on both sides, SHALL be provided.
REQ-002 Parameter DATA_WIDTH, 32, data width on both sides (multiple of 8), SHALL be provided.
REQ-003 Parameter TIMEOUT, 16, max ACCESS cycles awaiting PREADY (1..255), SHALL be provided.
REQ-004 Parameter PPROT_VAL, 3'b000, constant PPROT value, SHALL be provided.
REQ-005 PCLK_i  in  1  single clock for all logic, rising edge.
REQ-006 PRESETn_i  in  1  reset, asynchronous assert, active-low.
REQ-007 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-008 wb_adr_i  in  ADDR_WIDTH  byte address; wb_dat_i  in  DATA_WIDTH  write data.
REQ-009 wb_sel_i  in  DATA_WIDTH/8  byte selects.
REQ-010 wb_dat_o  out  DATA_WIDTH  read data; wb_ack_o, wb_err_o  out  1 each  termination.
REQ-011 PADDR_o  out  ADDR_WIDTH; PWDATA_o  out  DATA_WIDTH; PSTRB_o  out  DATA_WIDTH/8; PPROT_o  out  3.
REQ-012 PSEL_o, PENABLE_o, PWRITE_o  out  1 each  APB4 requester controls.
REQ-013 PRDATA_i  in  DATA_WIDTH; PREADY_i, PSLVERR_i  in  1 each  APB4 completer response.

Function
REQ-014 FSM states IDLE, SETUP, ACCESS, RESP SHALL be implemented; all outputs registered.
REQ-015 IDLE: wb_cyc_i & wb_stb_i sampled high -> latch adr/dat/sel/we into PADDR_o/PWDATA_o/PSTRB_o/PWRITE_o, PSEL_o=1, PENABLE_o=0, go SETUP.
REQ-016 SETUP: exactly one cycle; next state ACCESS with PENABLE_o=1, PSEL_o=1.
REQ-017 ACCESS: PADDR/PWDATA/PSTRB/PWRITE SHALL hold stable until PREADY_i sampled high.
REQ-018 ACCESS & PREADY_i: capture PRDATA_i into wb_dat_o on reads (writes leave wb_dat_o unchanged), deassert PSEL_o/PENABLE_o, go RESP.
REQ-019 RESP: one-cycle pulse of wb_ack_o (PSLVERR_i was 0) or wb_err_o (PSLVERR_i was 1), never both; return IDLE.
REQ-020 Latency with zero-wait completer: request sampled cycle N -> ack/err high cycle N+3.
REQ-021 PSTRB_o SHALL equal wb_sel_i for writes and all-zero for reads.
REQ-022 PPROT_o SHALL be PPROT_VAL constantly.
REQ-023 Timeout counter counts ACCESS cycles with PREADY_i low; reaching TIMEOUT -> drop PSEL_o/PENABLE_o, pulse wb_err_o in RESP, go IDLE.
REQ-024 PREADY_i high on the same cycle counter reaches TIMEOUT SHALL win: normal completion.
REQ-025 wb_cyc_i dropped during SETUP/ACCESS: APB transfer SHALL complete normally; ack/err suppressed in RESP.
REQ-026 New request SHALL NOT be accepted in RESP; back-to-back requests sampled earliest in IDLE following RESP.
REQ-027 PRDATA_i/PSLVERR_i SHALL be ignored outside ACCESS.

Reset
REQ-028 PRESETn_i low SHALL force IDLE, counter 0, PSEL_o=PENABLE_o=PWRITE_o=0, PADDR_o/PWDATA_o/PSTRB_o/wb_dat_o=0, wb_ack_o=wb_err_o=0, asynchronously.
REQ-029 Reset asserted mid-transfer SHALL abandon it with no ack/err; first request after deassertion sampled no earlier than the first rising edge with PRESETn_i high.

Structure
REQ-030 Package wb2apb_pkg SHALL hold the FSM state enum, default width constants and TIMEOUT counter width.
REQ-031 Single sub-module wb2apb_timeout (clear, enable, expired) SHALL implement the wait counter; remainder in wb2apb_bridge.

Verification
REQ-032 Write adr 0x0000_0010, dat 0xDEAD_BEEF, sel 4'b1111, PREADY tied 1 -> one SETUP, one ACCESS, PSTRB 4'hF, wb_ack_o at N+3.
REQ-033 Read adr 0x0000_0004, completer 3 wait states, PRDATA 0x1234_5678 -> PADDR stable 4 ACCESS cycles, wb_dat_o 0x1234_5678 with ack at N+6.
REQ-034 Write sel 4'b0011 with PSLVERR_i=1 on completion -> PSTRB 4'b0011, wb_err_o one cycle, wb_ack_o stays 0.
REQ-035 TIMEOUT=16, PREADY_i held 0 -> PSEL_o drops after 16 ACCESS cycles, wb_err_o pulses once, FSM IDLE; repeat with PREADY on 16th cycle -> ack.
REQ-036 wb_cyc_i dropped in SETUP -> APB completes, no ack/err; PRESETn_i low in ACCESS -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb2apb_pkg.sv
// Shared types and default sizes for the Wishbone-classic to APB4 bridge.
package wb2apb_pkg;

    // Bridge sequencing: request capture, APB setup, APB access, Wishbone response
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 16;

    // Wide enough for the largest supported TIMEOUT (255)
    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/wb2apb_timeout.sv
// Counts APB ACCESS cycles spent waiting for PREADY and flags the cycle on
// which the wait limit is reached.
module wb2apb_timeout
    import wb2apb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Count value present during the final permitted waiting cycle
    localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT - 1);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    // Next count: cleared outside ACCESS, saturating at the limit while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This waiting cycle is the TIMEOUT-th one; the caller decides whether
    // a simultaneous PREADY overrides it.
    assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/wb2apb_bridge.sv
// Wishbone classic slave to APB4 requester bridge. One transfer at a time,
// all outputs registered, with a bounded wait on PREADY.
module wb2apb_bridge
    import wb2apb_pkg::*;
#(
    parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int         TIMEOUT    = DEF_TIMEOUT,
    parameter logic [2:0] PPROT_VAL  = 3'b000
) (
    input  logic                    PCLK_i,
    input  logic                    PRESETn_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [ADDR_WIDTH-1:0]   PADDR_o,
    output logic [DATA_WIDTH-1:0]   PWDATA_o,
    output logic [DATA_WIDTH/8-1:0] PSTRB_o,
    output logic [2:0]              PPROT_o,
    output logic                    PSEL_o,
    output logic                    PENABLE_o,
    output logic                    PWRITE_o,
    input  logic [DATA_WIDTH-1:0]   PRDATA_i,
    input  logic                    PREADY_i,
    input  logic                    PSLVERR_i
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
    logic [STRB_W-1:0]       pstrb_q,   pstrb_d;
    logic                    pwrite_q,  pwrite_d;
    logic                    psel_q,    psel_d;
    logic                    penable_q, penable_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic                    ack_q,     ack_d;
    logic                    err_q,     err_d;
    logic                    abort_q,   abort_d;
    logic                    abort_now;
    logic                    to_clear;
    logic                    to_enable;
    logic                    to_expired;

    // The wait counter only runs while ACCESS is stalled on PREADY
    assign to_clear  = (state_q != ST_ACCESS);
    assign to_enable = (state_q == ST_ACCESS) && !PREADY_i;

    wb2apb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (PCLK_i),
        .rst_n     (PRESETn_i),
        .clear_i   (to_clear),
        .enable_i  (to_enable),
        .expired_o (to_expired)
    );

    // Next-state and next-output decode for the transfer sequencer
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        abort_d   = abort_q;
        // A master that has left the cycle gets no termination, but the
        // APB side is still carried through so the completer stays sane.
        abort_now = abort_q || !wb_cyc_i;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (wb_cyc_i && wb_stb_i) begin
                    paddr_d   = wb_adr_i;
                    pwdata_d  = wb_dat_i;
                    pstrb_d   = wb_we_i ? wb_sel_i : '0;
                    pwrite_d  = wb_we_i;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                abort_d   = abort_now;
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                abort_d = abort_now;
                // PREADY takes priority over a timeout landing on the same cycle
                if (PREADY_i) begin
                    if (!pwrite_q) begin
                        rdata_d = PRDATA_i;
                    end
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ack_d     = !PSLVERR_i && !abort_now;
                    err_d     = PSLVERR_i && !abort_now;
                    state_d   = ST_RESP;
                end else if (to_expired) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    err_d     = !abort_now;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers, cleared asynchronously
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
        end
    end

    assign PADDR_o   = paddr_q;
    assign PWDATA_o  = pwdata_q;
    assign PSTRB_o   = pstrb_q;
    assign PWRITE_o  = pwrite_q;
    assign PSEL_o    = psel_q;
    assign PENABLE_o = penable_q;
    assign PPROT_o   = PPROT_VAL;
    assign wb_dat_o  = rdata_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;

endmodule

// File: tb/tb_wb2apb_bridge.sv
// Directed bench for wb2apb_bridge: write, wait-stated read, slave error,
// timeout, cycle abort, back-to-back and asynchronous reset.
module tb_wb2apb_bridge;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        ack, err;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int vecs;
    int errs;

    wb2apb_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (16),
        .PPROT_VAL  (3'b000)
    ) dut (
        .PCLK_i    (clk),
        .PRESETn_i (rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (wdat),
        .wb_sel_i  (sel),
        .wb_dat_o  (rdat),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .PADDR_o   (paddr),
        .PWDATA_o  (pwdata),
        .PSTRB_o   (pstrb),
        .PPROT_o   (pprot),
        .PSEL_o    (psel),
        .PENABLE_o (penable),
        .PWRITE_o  (pwrite),
        .PRDATA_i  (prdata),
        .PREADY_i  (pready),
        .PSLVERR_i (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic drop();
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drop(); we = 1'b0; adr = '0; wdat = '0; sel = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        step(); step();
        vecs++; if (psel !== 1'b0) begin errs++; $display("FAIL rst_psel got %0h want 0", psel); end
        vecs++; if (penable !== 1'b0) begin errs++; $display("FAIL rst_penable got %0h want 0", penable); end
        vecs++; if ({ack, err} !== 2'b00) begin errs++; $display("FAIL rst_ack_err got %b want 00", {ack, err}); end
        vecs++; if (paddr !== 32'h0) begin errs++; $display("FAIL rst_paddr got %h want 0", paddr); end
        vecs++; if (rdat !== 32'h0) begin errs++; $display("FAIL rst_wb_dat got %h want 0", rdat); end
        vecs++; if (pprot !== 3'b000) begin errs++; $display("FAIL rst_pprot got %b want 000", pprot); end
        rst_n = 1'b1;
        step();
        vecs++; if (psel !== 1'b0) begin errs++; $display("FAIL idle_psel got %0h want 0", psel); end
    endtask

    task automatic test_write_zero_wait();
        pready = 1'b1;
        req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        step(); // SETUP
        vecs++; if ({psel, penable} !== 2'b10) begin errs++; $display("FAIL wr_setup_ctl got %b want 10", {psel, penable}); end
        vecs++; if (paddr !== 32'h10) begin errs++; $display("FAIL wr_paddr got %h want 00000010", paddr); end
        vecs++; if (pwdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL wr_pwdata got %h want deadbeef", pwdata); end
        vecs++; if (pstrb !== 4'hF) begin errs++; $display("FAIL wr_pstrb got %h want f", pstrb); end
        vecs++; if (pwrite !== 1'b1) begin errs++; $display("FAIL wr_pwrite got %0h want 1", pwrite); end
        vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL wr_early_ack got %0h want 0", ack); end
        step(); // ACCESS
        vecs++; if ({psel, penable} !== 2'b11) begin errs++; $display("FAIL wr_access_ctl got %b want 11", {psel, penable}); end
        vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL wr_access_ack got %0h want 0", ack); end
        step(); // RESP, cycle N+3
        vecs++; if ({ack, err} !== 2'b10) begin errs++; $display("FAIL wr_ack got %b want 10", {ack, err}); end
        vecs++; if ({psel, penable} !== 2'b00) begin errs++; $display("FAIL wr_resp_ctl got %b want 00", {psel, penable}); end
        drop();
        step(); // IDLE
        vecs++; if ({ack, err} !== 2'b00) begin errs++; $display("FAIL wr_ack_pulse got %b want 00", {ack, err}); end
        vecs++; if (psel !== 1'b0) begin errs++; $display("FAIL wr_idle_psel got %0h want 0", psel); end
    endtask

    task automatic test_read_wait_states();
        pready = 1'b0; pslverr = 1'b1; prdata = 32'hAAAA_5555;
        req(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'b1111);
        step(); // SETUP
        vecs++; if (pstrb !== 4'h0) begin errs++; $display("FAIL rd_pstrb got %h want 0", pstrb); end
        vecs++; if (pwrite !== 1'b0) begin errs++; $display("FAIL rd_pwrite got %0h want 0", pwrite); end
        pslverr = 1'b0;
        step(); // first ACCESS cycle
        for (int i = 0; i < 3; i++) begin
            vecs++; if ({psel, penable, paddr} !== {2'b11, 32'h4}) begin errs++; $display("FAIL rd_wait%0d got %b/%h want 11/00000004", i, {psel, penable}, paddr); end
            step();
        end
        vecs++; if ({psel, penable, paddr, ack} !== {2'b11, 32'h4, 1'b0}) begin errs++; $display("FAIL rd_access4 got %b/%h/%0h want 11/00000004/0", {psel, penable}, paddr, ack); end
        pready = 1'b1; prdata = 32'h1234_5678;
        step(); // RESP, cycle N+6
        vecs++; if ({ack, err} !== 2'b10) begin errs++; $display("FAIL rd_ack got %b want 10", {ack, err}); end
        vecs++; if (rdat !== 32'h1234_5678) begin errs++; $display("FAIL rd_data got %h want 12345678", rdat); end
        drop(); prdata = 32'h0;
        step();
        vecs++; if (rdat !== 32'h1234_5678) begin errs++; $display("FAIL rd_data_hold got %h want 12345678", rdat); end
    endtask

    task automatic test_slave_error();
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_0000;
        req(1'b1, 32'h0000_0020, 32'h0000_00AB, 4'b0011);
        step();
        vecs++; if (pstrb !== 4'b0011) begin errs++; $display("FAIL err_pstrb got %b want 0011", pstrb); end
        step();
        step(); // RESP
        vecs++; if ({ack, err} !== 2'b01) begin errs++; $display("FAIL err_resp got %b want 01", {ack, err}); end
        vecs++; if (rdat !== 32'h1234_5678) begin errs++; $display("FAIL err_wb_dat got %h want 12345678", rdat); end
        drop(); pslverr = 1'b0;
        step();
        vecs++; if ({ack, err} !== 2'b00) begin errs++; $display("FAIL err_pulse got %b want 00", {ack, err}); end
    endtask

    task automatic test_timeout(input logic late_ready);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hCAFE_F00D;
        req(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        step(); // SETUP
        step(); // ACCESS cycle 1
        for (int i = 0; i < 16; i++) begin
            vecs++; if ({psel, penable, err} !== 3'b110) begin errs++; $display("FAIL to_wait%0d got %b want 110", i, {psel, penable, err}); end
            if (i == 15) pready = late_ready;
            step();
        end
        vecs++; if (psel !== 1'b0) begin errs++; $display("FAIL to_psel_drop got %0h want 0", psel); end
        vecs++; if ({ack, err} !== {late_ready, !late_ready}) begin errs++; $display("FAIL to_resp got %b want %b", {ack, err}, {late_ready, !late_ready}); end
        if (late_ready) begin
            vecs++; if (rdat !== 32'hCAFE_F00D) begin errs++; $display("FAIL to_late_data got %h want cafef00d", rdat); end
        end
        drop(); pready = 1'b0;
        step();
        vecs++; if ({ack, err, psel} !== 3'b000) begin errs++; $display("FAIL to_idle got %b want 000", {ack, err, psel}); end
    endtask

    task automatic test_cyc_abort();
        pready = 1'b1;
        req(1'b1, 32'h0000_0080, 32'h5A5A_5A5A, 4'hF);
        step(); // SETUP
        drop();
        step(); // ACCESS continues
        vecs++; if ({psel, penable} !== 2'b11) begin errs++; $display("FAIL ab_access got %b want 11", {psel, penable}); end
        step(); // RESP
        vecs++; if ({ack, err, psel} !== 3'b000) begin errs++; $display("FAIL ab_resp got %b want 000", {ack, err, psel}); end
        step();
        vecs++; if ({ack, err} !== 2'b00) begin errs++; $display("FAIL ab_idle got %b want 00", {ack, err}); end
    endtask

    task automatic test_back_to_back();
        pready = 1'b1;
        req(1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF);
        step(); step(); step(); // RESP of first
        vecs++; if (ack !== 1'b1) begin errs++; $display("FAIL b2b_ack1 got %0h want 1", ack); end
        req(1'b1, 32'h0000_0104, 32'h2222_2222, 4'hF);
        step(); // IDLE: request must not have been taken in RESP
        vecs++; if ({psel, ack} !== 2'b00) begin errs++; $display("FAIL b2b_gap got %b want 00", {psel, ack}); end
        step(); // SETUP of second
        vecs++; if ({psel, penable, paddr} !== {2'b10, 32'h104}) begin errs++; $display("FAIL b2b_setup2 got %b/%h want 10/00000104", {psel, penable}, paddr); end
        step(); step();
        vecs++; if (ack !== 1'b1) begin errs++; $display("FAIL b2b_ack2 got %0h want 1", ack); end
        drop();
        step();
    endtask

    task automatic test_async_reset();
        pready = 1'b0;
        req(1'b1, 32'h0000_0200, 32'h7777_7777, 4'hF);
        step(); step(); // ACCESS
        #2 rst_n = 1'b0;
        #1;
        vecs++; if ({psel, penable, pwrite} !== 3'b000) begin errs++; $display("FAIL ar_ctl got %b want 000", {psel, penable, pwrite}); end
        vecs++; if ({paddr, pwdata, pstrb} !== 68'h0) begin errs++; $display("FAIL ar_data got %h/%h/%h want 0/0/0", paddr, pwdata, pstrb); end
        vecs++; if ({rdat, ack, err} !== 34'h0) begin errs++; $display("FAIL ar_wb got %h/%b want 0/00", rdat, {ack, err}); end
        pready = 1'b1;
        step();
        vecs++; if (psel !== 1'b0) begin errs++; $display("FAIL ar_held got %0h want 0", psel); end
        rst_n = 1'b1;
        step(); // first edge with reset released samples the request
        vecs++; if ({psel, penable, paddr} !== {2'b10, 32'h200}) begin errs++; $display("FAIL ar_restart got %b/%h want 10/00000200", {psel, penable}, paddr); end
        step(); step();
        vecs++; if ({ack, err} !== 2'b10) begin errs++; $display("FAIL ar_ack got %b want 10", {ack, err}); end
        drop();
        step();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_slave_error();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_cyc_abort();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
